// File: rtl/putlist_drain_sched_pkg.sv
// Shared put-list sizing and drain scheduler state encoding.
//   PUTLISTS  : number of put lists held by the list buffer
//   PUT_BITS  : width of a put-list index
//   PUTBEATS  : width of a per-request beat count (0..4)
`timescale 1ns/1ps
package putlist_drain_sched_pkg;

    localparam int unsigned PUTLISTS = 4;
    localparam int unsigned PUT_BITS = 2;
    localparam int unsigned PUTBEATS = 3;

    localparam int unsigned ST_W = 2;

    // Scheduler states
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/putlist_drain_sched_arb.sv
// rr_arb_oh: combinational round-robin arbiter.
// Search starts at (last_grant_i + 1) mod LISTS and wraps; the first set
// request bit wins.
//   req_i        : request vector
//   last_grant_i : index granted most recently
//   grant_o      : one-hot grant (all zero when no request)
//   grant_idx_o  : index of the granted bit (0 when no request)
`timescale 1ns/1ps
module rr_arb_oh #(
    parameter int unsigned LISTS = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [LISTS-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [LISTS-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic        w_found;
    int unsigned w_cand;

    // Walk the ring once, starting just after the previous winner.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        for (int unsigned i = 1; i <= LISTS; i++) begin
            w_cand = (32'(last_grant_i) + i) % LISTS;
            if (!w_found && req_i[IDX_W'(w_cand)]) begin
                grant_o[IDX_W'(w_cand)] = 1'b1;
                grant_idx_o             = IDX_W'(w_cand);
                w_found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/putlist_drain_sched.sv
// Put-list drain scheduler: accepts one per-list drain request at a time
// (round-robin), pops the granted list beat by beat as downstream accepts,
// then pulses done for one cycle.
//   clk, rst_n              : clock, async active-low reset
//   req_valid_i/req_beats_i : per-list drain request and beat count
//   req_ready_o             : one-hot grant (IDLE only)
//   list_valid_i            : list buffer per-list non-empty flags
//   pop_valid_o/pop_index_o : pop command to the list buffer
//   out_valid_o/out_ready_i : downstream beat handshake
//   out_last_o              : current beat is final beat of the drain
//   done_o/done_index_o     : drain-complete pulse and its list index
//   busy_o                  : scheduler not idle
`timescale 1ns/1ps
module putlist_drain_sched
    import putlist_drain_sched_pkg::*;
#(
    parameter int unsigned LISTS  = PUTLISTS,
    parameter int unsigned IDX_W  = PUT_BITS,
    parameter int unsigned BEAT_W = PUTBEATS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LISTS-1:0]        req_valid_i,
    input  logic [LISTS*BEAT_W-1:0] req_beats_i,
    output logic [LISTS-1:0]        req_ready_o,
    input  logic [LISTS-1:0]        list_valid_i,
    output logic                    pop_valid_o,
    output logic [IDX_W-1:0]        pop_index_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_last_o,
    output logic                    done_o,
    output logic [IDX_W-1:0]        done_index_o,
    output logic                    busy_o
);

    logic [ST_W-1:0]   r_state;
    logic [IDX_W-1:0]  r_cur_idx;
    logic [BEAT_W-1:0] r_cur_cnt;
    logic [IDX_W-1:0]  r_last_grant;

    logic [ST_W-1:0]   w_nxt_state;
    logic [IDX_W-1:0]  w_nxt_idx;
    logic [BEAT_W-1:0] w_nxt_cnt;
    logic [IDX_W-1:0]  w_nxt_last;

    logic [LISTS-1:0]  w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [BEAT_W-1:0] w_sel_beats;
    logic              w_idle;
    logic              w_drain;
    logic              w_out_valid;
    logic              w_pop;

    rr_arb_oh #(
        .LISTS (LISTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i        (req_valid_i),
        .last_grant_i (r_last_grant),
        .grant_o      (w_grant),
        .grant_idx_o  (w_grant_idx)
    );

    assign w_idle      = (r_state == ST_IDLE);
    assign w_drain     = (r_state == ST_DRAIN);
    assign w_out_valid = w_drain & list_valid_i[r_cur_idx];
    assign w_pop       = w_out_valid & out_ready_i;

    // Beat count of the granted list (grant is one-hot).
    always_comb begin
        w_sel_beats = '0;
        for (int unsigned k = 0; k < LISTS; k++) begin
            if (w_grant[k]) begin
                w_sel_beats = req_beats_i[k*BEAT_W +: BEAT_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cur_idx    <= '0;
            r_cur_cnt    <= '0;
            r_last_grant <= IDX_W'(LISTS - 1);
        end else begin
            r_state      <= w_nxt_state;
            r_cur_idx    <= w_nxt_idx;
            r_cur_cnt    <= w_nxt_cnt;
            r_last_grant <= w_nxt_last;
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_cur_idx;
        w_nxt_cnt   = r_cur_cnt;
        w_nxt_last  = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                // Any valid bit implies a grant, hence an acceptance.
                if (|w_grant) begin
                    w_nxt_idx   = w_grant_idx;
                    w_nxt_cnt   = w_sel_beats;
                    w_nxt_last  = w_grant_idx;
                    w_nxt_state = (w_sel_beats != '0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                // Guard at zero so the count can never wrap.
                if (w_pop && (r_cur_cnt != '0)) begin
                    w_nxt_cnt = r_cur_cnt - BEAT_W'(1);
                    if (r_cur_cnt == BEAT_W'(1)) begin
                        w_nxt_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; ready is masked by reset so every output
    // reads zero while rst_n is low.
    always_comb begin
        req_ready_o  = (w_idle && rst_n) ? w_grant : '0;
        out_valid_o  = w_out_valid;
        pop_valid_o  = w_pop;
        pop_index_o  = r_cur_idx;
        out_last_o   = w_out_valid & (r_cur_cnt == BEAT_W'(1));
        done_o       = (r_state == ST_DONE);
        done_index_o = r_cur_idx;
        busy_o       = ~w_idle;
    end

endmodule

// File: doc/putlist_drain_sched.md
PUTLIST_DRAIN_SCHED -- requirements
Module: putlist_drain_sched

Interface
REQ-001 SHALL have parameter LISTS, default 4, giving the number of put lists served, equal to the list buffer list count.
REQ-002 SHALL have parameter IDX_W, default 2, giving the list index width, equal to clog2(LISTS).
REQ-003 SHALL have parameter BEAT_W, default 3, giving the beat-count width, so that counts 0..4 are representable.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  LISTS  per-list drain request.
REQ-007 req_beats_i  input  LISTS*BEAT_W  per-list beats to drain; list k occupies bits [k*BEAT_W +: BEAT_W].
REQ-008 req_ready_o  output  LISTS  one-hot grant; a request is accepted when req_valid_i[k] and req_ready_o[k] are both high.
REQ-009 list_valid_i  input  LISTS  list-buffer per-list non-empty vector.
REQ-010 pop_valid_o  output  1  pop strobe to the list buffer.
REQ-011 pop_index_o  output  IDX_W  list to pop.
REQ-012 out_valid_o  output  1  the popped beat is presented downstream.
REQ-013 out_ready_i  input  1  downstream accepts the beat.
REQ-014 out_last_o  output  1  the current beat is the final beat of the drain.
REQ-015 done_o  output  1  one-cycle pulse after a drain completes.
REQ-016 done_index_o  output  IDX_W  list index of the completed drain.
REQ-017 busy_o  output  1  high while the state is not IDLE.

Function
REQ-018 SHALL implement three states: IDLE, DRAIN, DONE.
REQ-019 In IDLE with no req_valid_i bit set, SHALL drive req_ready_o=0.
REQ-020 In IDLE with any req_valid_i bit set, SHALL assert exactly one req_ready_o bit, chosen round-robin starting at (last_grant+1) mod LISTS, combinationally in the same cycle.
REQ-021 On acceptance SHALL latch cur_idx and cur_cnt from req_beats_i, set last_grant=cur_idx, and go to DRAIN if the count is nonzero, or to DONE if it is zero (no pops issued).
REQ-022 In DRAIN SHALL drive pop_index_o=cur_idx and out_valid_o=list_valid_i[cur_idx].
REQ-023 In DRAIN SHALL drive pop_valid_o = out_valid_o & out_ready_i, so a pop occurs only on a completed downstream handshake.
REQ-024 Outside DRAIN SHALL drive pop_valid_o=0 and out_valid_o=0, and pop_index_o SHALL hold cur_idx.
REQ-025 SHALL drive out_last_o = out_valid_o & (cur_cnt==1).
REQ-026 On each pop SHALL decrement cur_cnt; a pop with cur_cnt==1 SHALL move the state to DONE.
REQ-027 While list_valid_i[cur_idx]=0 in DRAIN, SHALL stall (no pop, no count change) indefinitely; a drain is never abandoned.
REQ-028 In DONE SHALL pulse done_o=1 with done_index_o=cur_idx for one cycle, then return to IDLE; there is one idle bubble between drains.
REQ-029 Outside IDLE SHALL hold req_ready_o=0, so a new request for the list being drained waits.
REQ-030 last_grant SHALL wrap from LISTS-1 to 0.
REQ-031 cur_cnt SHALL never underflow; no decrement at 0.
REQ-032 req_valid_i is not required to be held after acceptance; the latched values alone govern the drain.

Reset
REQ-033 Asserting rst_n low SHALL immediately reset: state=IDLE, cur_idx=0, cur_cnt=0, last_grant=LISTS-1 (so list 0 wins first), done_o=0, and all other outputs 0.
REQ-034 Reset asserted during DRAIN SHALL abort the drain with no done_o pulse; the list buffer is reset by the same rst_n.

Structure
REQ-035 The list count, put index width and beat count SHALL be taken from the shared define file (PUTLISTS, PUT_BITS, PUTBEATS) and used to set LISTS, IDX_W and BEAT_W.
REQ-036 SHALL contain one sub-module, rr_arb_oh, a combinational round-robin one-hot arbiter (req, last_grant -> grant one-hot, grant index).
REQ-037 SHALL connect to the list buffer only through pop_valid/pop_index/list_valid, with no datapath inside this block.

Verification
REQ-038 Reset release, req_valid_i=4'b0001, beats=2, out_ready_i=1, list 0 valid -> grant the same cycle, pops on cycles 2 and 3 with out_last_o on the second, done_o at cycle 4 with done_index_o=0.
REQ-039 Requests 4'b1111 held continuously, each with beats=1 -> grant order 0,1,2,3,0, and done_o pulses 3 cycles apart.
REQ-040 In DRAIN idx=2, beats=3, out_ready_i toggled 1,0,1,0,1 -> exactly 3 pops, occurring only on the ready-high cycles.
REQ-041 In DRAIN, list_valid_i[idx] held low for 5 cycles -> no pop and count held for those cycles, then the drain resumes and completes.
REQ-042 beats=0 accepted -> no pop_valid_o, done_o the next cycle.
REQ-043 rst_n pulsed low mid-DRAIN -> all outputs 0 immediately, no done_o pulse, and the next grant goes to list 0.
